// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: size codes,
// arbiter FSM encoding and size helpers.
package mem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Number of bytes touched by an access; 0 for the illegal code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_WORD: return 3'd4;
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd0;
        endcase
    endfunction

    // Zero-extension mask applied to RAM read data.
    function automatic logic [31:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_WORD: return 32'hFFFF_FFFF;
            SIZE_BYTE: return 32'h0000_00FF;
            SIZE_HALF: return 32'h0000_FFFF;
            default:   return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for a data access: size code, natural
// alignment and range. Shared with the fetch path, so it has no state.
module mem_access_check
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 256
) (
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    output logic        legal
);

    logic [32:0] end_addr;
    logic        aligned;

    // End address is formed in 33 bits so an address near 2^32 cannot wrap back into range.
    always_comb begin
        end_addr = {1'b0, addr} + {30'd0, size_bytes(size)};
        case (size)
            SIZE_WORD: aligned = (addr[1:0] == 2'b00);
            SIZE_HALF: aligned = ~addr[0];
            SIZE_BYTE: aligned = 1'b1;
            default:   aligned = 1'b0;
        endcase
        legal = aligned && (end_addr <= 33'(MEM_BYTES));
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the MEM stage (m0) and the
// loader/debug port (m1). One access at a time: IDLE -> ACCESS -> RESP,
// or IDLE -> RESP directly when the access is rejected.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a request; grant, latch command, check legality
// ST_ACCESS | single RAM cycle driven from registered mem_* outputs
// ST_RESP   | ack (and err/rdata) pulse to the granted master
module data_mem_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = 256,
    parameter bit RR_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        mem_enable,
    output logic        mem_rw,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    state_t      state;
    logic        grant_q;
    logic        rr_last;
    logic        cmd_rw_q;
    logic [1:0]  cmd_size_q;

    logic        any_req;
    logic        sel;
    logic        sel_rw;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_legal;
    logic [31:0] read_data;

    // Grant decision and command mux for the master that would win this cycle.
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            sel = RR_EN ? ~rr_last : 1'b0;
        end else begin
            sel = m1_req;
        end
        if (sel) begin
            sel_rw    = m1_rw;
            sel_size  = m1_size;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end else begin
            sel_rw    = m0_rw;
            sel_size  = m0_size;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end
    end

    mem_access_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .addr  (sel_addr),
        .size  (sel_size),
        .legal (sel_legal)
    );

    // Read data is zero-extended to the access size; writes return zero.
    always_comb begin
        read_data = cmd_rw_q ? 32'h0 : (mem_rdata & size_mask(cmd_size_q));
    end

    // Arbiter FSM with registered outputs; outputs default to 0 and are set only in their cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            grant_q    <= 1'b0;
            rr_last    <= 1'b1;
            cmd_rw_q   <= 1'b0;
            cmd_size_q <= 2'b00;
            busy       <= 1'b0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= 32'h0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= 32'h0;
            mem_enable <= 1'b0;
            mem_rw     <= 1'b0;
            mem_size   <= 2'b00;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= 32'h0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= 32'h0;
            mem_enable <= 1'b0;
            mem_rw     <= 1'b0;
            mem_size   <= 2'b00;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q    <= sel;
                        cmd_rw_q   <= sel_rw;
                        cmd_size_q <= sel_size;
                        busy       <= 1'b1;
                        if (sel_legal) begin
                            state      <= ST_ACCESS;
                            mem_enable <= 1'b1;
                            mem_rw     <= sel_rw;
                            mem_size   <= sel_size;
                            mem_addr   <= sel_addr;
                            mem_wdata  <= sel_wdata;
                        end else begin
                            // Rejected: skip the RAM entirely and respond next cycle.
                            state <= ST_RESP;
                            if (sel) begin
                                m1_ack <= 1'b1;
                                m1_err <= 1'b1;
                            end else begin
                                m0_ack <= 1'b1;
                                m0_err <= 1'b1;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    state <= ST_RESP;
                    if (grant_q) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= read_data;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= read_data;
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    rr_last <= grant_q;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a big-endian RAM stub behind the DUT, a
// separate reference byte array as the model, directed scenarios and a
// randomized single-master sweep. A second instance runs fixed priority.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        m0_req, m0_rw, m1_req, m1_rw;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_enable, mem_rw, busy;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_mem_enable, fp_mem_rw, fp_busy;
    logic [1:0]  fp_mem_size;
    logic [31:0] fp_mem_addr, fp_mem_wdata, fp_mem_rdata;

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];

    data_mem_arbiter #(.MEM_BYTES(256), .RR_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    assign fp_mem_rdata = 32'h0;

    data_mem_arbiter #(.MEM_BYTES(256), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(fp_m0_ack), .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(fp_m1_ack), .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
        .mem_enable(fp_mem_enable), .mem_rw(fp_mem_rw), .mem_size(fp_mem_size), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .busy(fp_busy)
    );

    // RAM stub: big-endian, right-justified data; junk in unused upper bits.
    logic [7:0] ra;
    always_comb begin
        ra = mem_addr[7:0];
        case (mem_size)
            2'b01:   mem_rdata = {24'hA5C3E1, ram[ra]};
            2'b10:   mem_rdata = {16'h5A3C, ram[ra], ram[ra + 8'd1]};
            default: mem_rdata = {ram[ra], ram[ra + 8'd1], ram[ra + 8'd2], ram[ra + 8'd3]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_enable) en_cnt <= en_cnt + 1;
        if (mem_enable && mem_rw) begin
            case (mem_size)
                2'b01: ram[ra] <= mem_wdata[7:0];
                2'b10: begin
                    ram[ra]        <= mem_wdata[15:8];
                    ram[ra + 8'd1] <= mem_wdata[7:0];
                end
                default: begin
                    ram[ra]        <= mem_wdata[31:24];
                    ram[ra + 8'd1] <= mem_wdata[23:16];
                    ram[ra + 8'd2] <= mem_wdata[15:8];
                    ram[ra + 8'd3] <= mem_wdata[7:0];
                end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] s);
        if (s == 2'b00) return 4;
        if (s == 2'b01) return 1;
        if (s == 2'b10) return 2;
        return 0;
    endfunction

    function automatic bit is_legal(input logic [31:0] a, input logic [1:0] s);
        longint unsigned n, ea;
        n = longint'(nbytes(s));
        if (n == 0) return 1'b0;
        if ((64'(a) % n) != 0) return 1'b0;
        ea = 64'(a) + n;
        return ea <= 256;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [1:0] s);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = nbytes(s);
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[int'(a[7:0]) + i]);
        return v;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
        int n;
        n = nbytes(s);
        for (int i = 0; i < n; i++) ref_mem[int'(a[7:0]) + i] = 8'(w >> (8 * (n - 1 - i)));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic txn(input int m, input logic rw, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output bit got, output logic err,
                       output logic [31:0] rdata, output int lat, output bit stray, output int en_delta);
        int en0;
        got = 0; err = 1'b0; rdata = 32'h0; lat = 0; stray = 0;
        @(negedge clk);
        en0 = en_cnt;
        if (m == 0) begin
            m0_req = 1'b1; m0_rw = rw; m0_size = size; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = 1'b1; m1_rw = rw; m1_size = size; m1_addr = addr; m1_wdata = wdata;
        end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if ((m == 0) ? m1_ack : m0_ack) stray = 1;
            if ((m == 0) ? m0_ack : m1_ack) begin
                got   = 1;
                lat   = c;
                err   = (m == 0) ? m0_err : m1_err;
                rdata = (m == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk); #1;
        en_delta = en_cnt - en0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        m0_req = 1'b0; m0_rw = 1'b0; m0_size = 2'b00; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_rw = 1'b0; m1_size = 2'b00; m1_addr = 32'h0; m1_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (mem_enable !== 1'b0) begin bad++; $display("FAIL reset_mem_enable got=%b exp=0", mem_enable); end
        total++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin bad++; $display("FAIL reset_ack_err got=%b exp=0000", {m0_ack, m0_err, m1_ack, m1_err}); end
        total++; if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'h0) begin bad++; $display("FAIL reset_data_outputs not zero addr=%h wdata=%h r0=%h r1=%h", mem_addr, mem_wdata, m0_rdata, m1_rdata); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_read_word();
        bit got, stray; logic err; logic [31:0] rd; int lat, en;
        txn(0, 1'b0, 2'b00, 32'h10, 32'h0, got, err, rd, lat, stray, en);
        total++; if (!got || lat != 2) begin bad++; $display("FAIL rdword_latency got=%0d exp=2 acked=%0d", lat, got); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rdword_err got=%b exp=0", err); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rdword_data got=%h exp=deadbeef", rd); end
        total++; if (stray || en != 1) begin bad++; $display("FAIL rdword_side stray=%0d enables=%0d exp 0/1", stray, en); end
    endtask

    task automatic test_simultaneous();
        bit got, stray; logic err; logic [31:0] rd; int lat, en;
        int t0, t1;
        apply_reset();
        t0 = 0; t1 = 0;
        @(negedge clk);
        m0_req = 1'b1; m0_rw = 1'b1; m0_size = 2'b01; m0_addr = 32'h20; m0_wdata = 32'h0000_00AA;
        m1_req = 1'b1; m1_rw = 1'b1; m1_size = 2'b01; m1_addr = 32'h21; m1_wdata = 32'h0000_0055;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (m0_ack && m1_ack) begin total++; bad++; $display("FAIL sim_both_acked cycle=%0d", c); end
            if (m0_ack && t0 == 0) begin t0 = c; m0_req = 1'b0; end
            if (m1_ack && t1 == 0) begin t1 = c; m1_req = 1'b0; end
            if (t0 != 0 && t1 != 0) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(posedge clk);
        model_write(32'h20, 2'b01, 32'hAA);
        model_write(32'h21, 2'b01, 32'h55);
        total++; if (t0 != 2) begin bad++; $display("FAIL sim_m0_ack_cycle got=%0d exp=2", t0); end
        total++; if (t1 != 5) begin bad++; $display("FAIL sim_m1_ack_cycle got=%0d exp=5", t1); end
        txn(0, 1'b0, 2'b01, 32'h20, 32'h0, got, err, rd, lat, stray, en);
        total++; if (!got || err !== 1'b0 || rd !== 32'hAA) begin bad++; $display("FAIL sim_readback_20 got=%h err=%b exp=000000aa", rd, err); end
        txn(1, 1'b0, 2'b01, 32'h21, 32'h0, got, err, rd, lat, stray, en);
        total++; if (!got || err !== 1'b0 || rd !== 32'h55) begin bad++; $display("FAIL sim_readback_21 got=%h err=%b exp=00000055", rd, err); end
    endtask

    task automatic test_errors();
        bit got, stray; logic err; logic [31:0] rd; int lat, en;
        logic [1:0]  sz [3];
        logic [31:0] ad [3];
        sz[0] = 2'b00; ad[0] = 32'h13;
        sz[1] = 2'b10; ad[1] = 32'h05;
        sz[2] = 2'b11; ad[2] = 32'h08;
        for (int i = 0; i < 3; i++) begin
            txn(0, 1'b0, sz[i], ad[i], 32'h0, got, err, rd, lat, stray, en);
            total++; if (!got || lat != 1 || err !== 1'b1) begin bad++; $display("FAIL err_case%0d lat=%0d exp=1 err=%b exp=1", i, lat, err); end
            total++; if (en != 0) begin bad++; $display("FAIL err_case%0d_enable got=%0d exp=0", i, en); end
        end
    endtask

    task automatic test_range();
        bit got, stray; logic err; logic [31:0] rd; int lat, en;
        logic [31:0] ad [5];
        logic [1:0]  sz [5];
        bit          lg;
        ad[0] = 32'hFC;       sz[0] = 2'b00;
        ad[1] = 32'hFD;       sz[1] = 2'b00;
        ad[2] = 32'hFF;       sz[2] = 2'b10;
        ad[3] = 32'hFF;       sz[3] = 2'b01;
        ad[4] = 32'hFFFFFFFF; sz[4] = 2'b01;
        for (int i = 0; i < 5; i++) begin
            lg = (i == 0 || i == 3);
            txn(1, 1'b0, sz[i], ad[i], 32'h0, got, err, rd, lat, stray, en);
            total++; if (!got || err !== !lg || lat != (lg ? 2 : 1)) begin bad++; $display("FAIL range_case%0d err=%b lat=%0d exp_err=%0d", i, err, lat, !lg); end
            if (lg) begin
                total++; if (rd !== exp_read(ad[i], sz[i])) begin bad++; $display("FAIL range_case%0d_data got=%h exp=%h", i, rd, exp_read(ad[i], sz[i])); end
            end
        end
    endtask

    task automatic test_contention();
        int seq [$];
        int fp0, fp1;
        apply_reset();
        fp0 = 0; fp1 = 0;
        @(negedge clk);
        m0_req = 1'b1; m0_rw = 1'b0; m0_size = 2'b01; m0_addr = 32'h00; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_rw = 1'b0; m1_size = 2'b01; m1_addr = 32'h01; m1_wdata = 32'h0;
        for (int c = 1; c <= 60 && seq.size() < 8; c++) begin
            @(posedge clk); #1;
            if (m0_ack) seq.push_back(0);
            if (m1_ack) seq.push_back(1);
            if (fp_m0_ack) fp0++;
            if (fp_m1_ack) fp1++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (6) @(posedge clk);
        total++; if (seq.size() != 8) begin bad++; $display("FAIL rr_count got=%0d exp=8", seq.size()); end
        for (int i = 0; i < seq.size(); i++) begin
            total++; if (seq[i] != (i % 2)) begin bad++; $display("FAIL rr_order idx=%0d got=m%0d exp=m%0d", i, seq[i], i % 2); end
        end
        total++; if (fp1 != 0) begin bad++; $display("FAIL fixed_prio_m1_acks got=%0d exp=0", fp1); end
        total++; if (fp0 < 7) begin bad++; $display("FAIL fixed_prio_m0_acks got=%0d exp>=7", fp0); end
    endtask

    task automatic test_reset_mid();
        bit got, stray; logic err; logic [31:0] rd; int lat, en;
        bit late_ack;
        @(negedge clk);
        m0_req = 1'b1; m0_rw = 1'b1; m0_size = 2'b00; m0_addr = 32'h40; m0_wdata = 32'h11223344;
        @(posedge clk); #1;
        total++; if (mem_enable !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL midrst_access en=%b busy=%b exp 1/1", mem_enable, busy); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        m0_req = 1'b0;
        total++; if (busy !== 1'b0 || mem_enable !== 1'b0 || m0_ack !== 1'b0) begin bad++; $display("FAIL midrst_abort busy=%b en=%b ack=%b exp 0/0/0", busy, mem_enable, m0_ack); end
        @(negedge clk);
        reset_n = 1'b1;
        late_ack = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) late_ack = 1;
        end
        total++; if (late_ack) begin bad++; $display("FAIL midrst_late_ack got=1 exp=0"); end
        // The write was enabled at the aborting edge, so the stub took it.
        model_write(32'h40, 2'b00, 32'h11223344);
        txn(0, 1'b0, 2'b00, 32'h40, 32'h0, got, err, rd, lat, stray, en);
        total++; if (!got || lat != 2 || err !== 1'b0 || rd !== exp_read(32'h40, 2'b00)) begin bad++; $display("FAIL midrst_fresh lat=%0d err=%b got=%h exp=%h", lat, err, rd, exp_read(32'h40, 2'b00)); end
    endtask

    task automatic test_random();
        bit got, stray; logic err; logic [31:0] rd; int lat, en;
        int m, r; logic rw; logic [1:0] sz; logic [31:0] ad, wd; bit lg;
        for (int k = 0; k < 40; k++) begin
            m  = int'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            if (r < 7)       ad = 32'($urandom_range(0, 259));
            else if (r == 7) ad = $urandom;
            else             ad = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            wd = $urandom;
            lg = is_legal(ad, sz);
            txn(m, rw, sz, ad, wd, got, err, rd, lat, stray, en);
            total++; if (!got || lat != (lg ? 2 : 1) || err !== !lg) begin bad++; $display("FAIL rand%0d_resp m=%0d a=%h s=%0d lat=%0d err=%b exp_err=%0d", k, m, ad, sz, lat, err, !lg); end
            total++; if (stray || en != (lg ? 1 : 0)) begin bad++; $display("FAIL rand%0d_side stray=%0d enables=%0d exp=%0d", k, stray, en, lg ? 1 : 0); end
            if (lg && !rw) begin
                total++; if (rd !== exp_read(ad, sz)) begin bad++; $display("FAIL rand%0d_data a=%h s=%0d got=%h exp=%h", k, ad, sz, rd, exp_read(ad, sz)); end
            end
            if (lg && rw) model_write(ad, sz, wd);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[16'h10] = 8'hDE; ram[16'h11] = 8'hAD; ram[16'h12] = 8'hBE; ram[16'h13] = 8'hEF;
        ref_mem[16'h10] = 8'hDE; ref_mem[16'h11] = 8'hAD; ref_mem[16'h12] = 8'hBE; ref_mem[16'h13] = 8'hEF;

        test_reset();
        test_read_word();
        test_simultaneous();
        test_errors();
        test_range();
        test_contention();
        test_reset_mid();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
